// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: binary-to-BCD converter and four-digit seven-segment scanner.
// Ports: clk, rst (sync, active-high), value_in[12:0] + update (capture request),
//        busy (conversion pending/running), Anode[3:0] (active-low digit enable,
//        bit 0 = ones), LED_out[6:0] (segments {a..g}, active-low).
module ssd_scan_ctrl #(
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] value_in,
    input  logic        update,
    output logic        busy,
    output logic [3:0]  Anode,
    output logic [6:0]  LED_out
);

    localparam int CW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_e;

    state_e      state_q, state_d;
    logic        pending_q, pending_d;
    logic        busy_q;
    logic [12:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  iter_q, iter_d;
    logic [15:0] disp_q, disp_d;
    logic [15:0] bcd_adj;

    logic [CW-1:0] ref_q, ref_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    anode_q, anode_d;
    logic [6:0]    seg_q, seg_d;
    logic          wrap;
    logic [3:0]    nib;
    logic [3:0]    lead_zero;
    logic          blank;

    // Add-3 correction on every BCD nibble before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        iter_d    = iter_q;
        disp_d    = disp_q;
        unique case (state_q)
            IDLE: begin
                if (update || pending_q) begin
                    bin_d     = value_in;
                    bcd_d     = '0;
                    iter_d    = '0;
                    pending_d = 1'b0;
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, bin_d} = {bcd_adj[14:0], bin_q, 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd12) begin
                    state_d = COMMIT;
                end
                if (update) begin
                    pending_d = 1'b1;
                end
            end
            COMMIT: begin
                disp_d  = bcd_q;
                state_d = IDLE;
                if (update) begin
                    pending_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan path: digit slot counter and registered anode/segment drive.
    assign wrap = (ref_q == CW'(REFRESH_DIV - 1));
    assign ref_d = wrap ? '0 : ref_q + 1'b1;
    assign idx_d = wrap ? idx_q + 2'd1 : idx_q;
    assign nib = disp_q[{idx_q, 2'b00} +: 4];

    // lead_zero[k]: digit k and every digit above it are zero.
    assign lead_zero[3] = (disp_q[15:12] == 4'd0);
    assign lead_zero[2] = lead_zero[3] && (disp_q[11:8] == 4'd0);
    assign lead_zero[1] = lead_zero[2] && (disp_q[7:4] == 4'd0);
    assign lead_zero[0] = 1'b0;
    assign blank = BLANK_LEADING && lead_zero[idx_q];

    always_comb begin
        anode_d = ~(4'b0001 << idx_q);
        seg_d   = 7'b1111111;
        if (!blank) begin
            case (nib)
                4'd0:    seg_d = 7'b0000001;
                4'd1:    seg_d = 7'b1001111;
                4'd2:    seg_d = 7'b0010010;
                4'd3:    seg_d = 7'b0000110;
                4'd4:    seg_d = 7'b1001100;
                4'd5:    seg_d = 7'b0100100;
                4'd6:    seg_d = 7'b0100000;
                4'd7:    seg_d = 7'b0001111;
                4'd8:    seg_d = 7'b0000000;
                4'd9:    seg_d = 7'b0000100;
                default: seg_d = 7'b1111111;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            bin_q     <= '0;
            bcd_q     <= '0;
            iter_q    <= '0;
            disp_q    <= '0;
            ref_q     <= '0;
            idx_q     <= '0;
            anode_q   <= 4'b1110;
            seg_q     <= 7'b0000001;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            busy_q    <= (state_d != IDLE) || pending_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            iter_q    <= iter_d;
            disp_q    <= disp_d;
            ref_q     <= ref_d;
            idx_q     <= idx_d;
            anode_q   <= anode_d;
            seg_q     <= seg_d;
        end
    end

    assign busy    = busy_q;
    assign Anode   = anode_q;
    assign LED_out = seg_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: scoreboard bench for ssd_scan_ctrl.
// Two instances (blanking on/off) share stimulus; commits are checked on busy fall.
module tb_ssd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] value_in;
    logic        update;
    logic        busy, busy_nb;
    logic [3:0]  Anode, Anode_nb;
    logic [6:0]  LED_out, LED_nb;

    int n_tests = 0;
    int n_fail  = 0;
    int pushes  = 0;
    int mon_done = 0;
    bit armed = 1'b0;

    typedef struct {
        int value;
        int blen;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    ssd_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u_dut (
        .clk(clk), .rst(rst), .value_in(value_in), .update(update),
        .busy(busy), .Anode(Anode), .LED_out(LED_out)
    );

    ssd_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) u_nb (
        .clk(clk), .rst(rst), .value_in(value_in), .update(update),
        .busy(busy_nb), .Anode(Anode_nb), .LED_out(LED_nb)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int aidx(logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(int v, int k, bit blank);
        int p;
        int d;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        d = (v / p) % 10;
        if (blank && k > 0 && v < p) return 7'b1111111;
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            default: return 7'b0000100;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one cycle of the scanned display of both instances against value v.
    task automatic chk_shown(string name, int v);
        int k;
        int kn;
        k  = aidx(Anode);
        kn = aidx(Anode_nb);
        if (k < 0 || kn < 0) begin
            chk({name, "_anode"}, {Anode, Anode_nb}, 8'hEE);
        end else begin
            chk({name, "_blank"}, LED_out, exp_seg(v, k, 1'b1));
            chk({name, "_noblank"}, LED_nb, exp_seg(v, kn, 1'b0));
        end
    endtask

    task automatic check_display(string name, int v);
        repeat (16) begin
            @(negedge clk);
            chk_shown(name, v);
        end
    endtask

    task automatic issue(int vin, int vexp, int blen);
        exp_t e;
        e.value = vexp;
        e.blen  = blen;
        sb.push_back(e);
        pushes++;
        value_in = 13'(vin);
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    task automatic wait_mon();
        int t;
        t = 0;
        while (mon_done != pushes && t < 300) begin
            tick();
            t++;
        end
        chk("mon_timeout", mon_done, pushes);
        tick();
    endtask

    // Exactly one anode low on every cycle once reset has been applied.
    always @(negedge clk) begin
        if (armed) begin
            chk("onehot", $countones(~Anode), 1);
            chk("onehot_nb", $countones(~Anode_nb), 1);
        end
    end

    // Monitor: a busy run ending without reset is a commit; pop and compare.
    initial begin : monitor
        int run;
        exp_t e;
        run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else if (busy) begin
                run++;
            end else if (run > 0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_commit", run, 0);
                    e.value = 0;
                end else begin
                    e = sb.pop_front();
                    chk("busy_len", run, e.blen);
                end
                run = 0;
                @(negedge clk);
                check_display("commit_disp", e.value);
                mon_done++;
            end
        end
    end

    initial begin : stim
        int prevk;
        int run;
        int nruns;
        bit started;
        logic [3:0] prev;
        logic [3:0] nexp;

        rst = 1'b1;
        update = 1'b0;
        value_in = '0;
        tick();
        armed = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_anode", Anode, 4'b1110);
        chk("rst_led", LED_out, 7'b0000001);
        chk("rst_busy", busy, 1'b0);
        check_display("rst_disp", 0);

        // Full-scale, blanking and assorted values
        tick();
        issue(8191, 8191, 14);
        wait_mon();
        issue(5, 5, 14);
        wait_mon();
        issue(0, 0, 14);
        wait_mon();
        issue(1000, 1000, 14);
        wait_mon();
        issue(4095, 4095, 14);
        wait_mon();

        // Overlapping requests collapse to one follow-up with the latest value
        issue(1234, 42, 29);
        tick();
        tick();
        value_in = 13'd77;
        update = 1'b1;
        tick();
        update = 1'b0;
        repeat (4) tick();
        value_in = 13'd600;
        update = 1'b1;
        tick();
        update = 1'b0;
        value_in = 13'd42;
        repeat (12) tick();
        @(negedge clk);
        chk_shown("ovl_first", 1234);
        wait_mon();

        // Reset in the middle of converting 999
        value_in = 13'd999;
        update = 1'b1;
        tick();
        update = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_anode", Anode, 4'b1110);
        chk("mid_rst_led", LED_out, 7'b0000001);
        check_display("mid_rst_disp", 0);
        repeat (20) begin
            @(negedge clk);
            chk("mid_rst_idle", busy, 1'b0);
        end
        check_display("no_999", 0);

        // Scan wrap: every complete slot lasts 4 cycles, in rotating order
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        prev = Anode;
        run = 1;
        nruns = 0;
        started = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (Anode == prev) begin
                run++;
            end else begin
                if (started) begin
                    chk("scan_hold", run, 4);
                    nruns++;
                end
                prevk = aidx(prev);
                nexp = ~(4'b0001 << ((prevk + 1) % 4));
                chk("scan_order", Anode, nexp);
                started = 1'b1;
                prev = Anode;
                run = 1;
            end
        end
        chk("scan_runs", nruns >= 12, 1'b1);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
